bowling_scorer: RTL
===================

# bowling_scorer

Clocked, parametrised bowling score engine for multiple players. It takes a pin count and a push-button, and applies full strike, spare and final-frame fill-ball rules. It rejects illegal rolls and drives packed per-player totals plus three 7-segment digits for the active player. It supersedes the unclocked single-player scorer as the core of the bowling board top level.

## Interface
- PLAYERS, 2, number of players (1..8), rotating after each completed frame
- FRAMES, 10, frames per game (2..15); the last frame gets fill balls
- SCORE_W, 11, bits per player total
- clk  in  1  single system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- pointIn  in  4  pins knocked on this roll (0..10 legal)
- button  in  1  raw, asynchronous "roll entered" level; a rising edge commits pointIn
- pointAll  out  PLAYERS*SCORE_W  player p total in bits [p*SCORE_W +: SCORE_W]
- curPlayer  out  max(1,$clog2(PLAYERS))  player whose roll is awaited
- curFrame  out  4  frame of curPlayer, 1..FRAMES
- rollInFrame  out  2  roll index within the frame, 0..2
- gameOver  out  1  high once the last player completes frame FRAMES
- illegal  out  1  one-cycle pulse when a committed roll is rejected
- hundred7SegCode, ten7SegCode  out  7  hundreds and tens digit of curPlayer total
- current7SegCode  out  7  last accepted roll value

## Operation
- Button path:
  - 2-FF synchroniser, then a registered previous-value flop.
  - commit = sync & ~prev.
  - Holding button high produces one commit only.
- Commit while gameOver=1: ignored. No state change, no illegal pulse.
- Legality:
  - pointIn > 10 is illegal.
  - On a second roll in a non-reset rack, first + pointIn > 10 is illegal.
  - An illegal roll pulses illegal and leaves all other state unchanged.
- Bonus state per player:
  - m1 is the extra multiplier for the next roll (0..2).
  - m2 is the extra multiplier for the roll after that (0..1).
- Frames 1..FRAMES-1, accepted roll v:
  - total += v*(1+m1)
  - strike (roll 0, v=10): m1 <= m2+1, m2 <= 1; the frame ends.
  - spare (roll 1, sum=10): m1 <= m2+1, m2 <= 0.
  - otherwise: m1 <= m2, m2 <= 0.
- Final frame, accepted roll v:
  - total += v*(1+m1); m1 <= m2; m2 <= 0; no new bonuses are created.
  - Roll 0 strike: two fill rolls follow.
  - Roll 1 after a strike: any 0..10; the rack resets only if that roll is 10.
  - Spare on rolls 0+1: roll 2 allowed, with a fresh rack.
  - Open after roll 1: the frame ends.
- Frame end:
  - rollInFrame <= 0.
  - curPlayer advances modulo PLAYERS; curFrame increments when curPlayer wraps to 0.
  - Completing the last player's final frame sets gameOver, curPlayer <= 0, curFrame holds FRAMES.
- Totals saturate at 2^SCORE_W-1.
- Display:
  - Digits are ((total/100)%10) and ((total/10)%10) of curPlayer.
  - Segments are ordered [0:6]=a..g, active-high.
  - Digits 0..9 use the standard encoding; the value 10 on current7SegCode shows only segment g (dash).

## Timing
- Reset values:
  - all totals, m1 and m2 are 0
  - curPlayer=0, curFrame=1, rollInFrame=0, gameOver=0, illegal=0
  - all three 7-segment outputs show '0' (1111110)
- Reset is asserted asynchronously and released synchronously through the internal flops. The first commit is possible 3 edges after button rises post-release.
- Latency:
  - button high before edge k: commit is true between edges k+1 and k+2.
  - All outputs update at edge k+2.
  - illegal is high for exactly the cycle after edge k+2.
- The 7-segment outputs are combinational from registered state: same-cycle as pointAll.
- Minimum spacing between commits: button must be low for at least 2 clk cycles.
- Reset during a commit or mid-game: everything returns to reset values at once, and the pending commit is lost.

## Test plan
- Perfect game, PLAYERS=1:
  - 12 commits of 10 -> pointAll=300, hundred7SegCode='3', ten7SegCode='0', gameOver=1 after the 12th.
  - A 13th commit produces no change and no illegal pulse.
- Spare bonus: 7,3,4,2 -> totals after each commit are 7, 10, 18, 20; curFrame=3 afterwards.
- Illegal rolls:
  - pointIn=11 -> illegal pulses once, state unchanged.
  - 6 then 5 -> the 5 is rejected; a following 4 is accepted (total 10, spare pending).
- Rotation, PLAYERS=2: P0 rolls 3,4; P1 rolls 10; P0 rolls 5 -> curPlayer sequence 0,0,1,0; P0=12, P1=10, curFrame=2.
- Final frame, FRAMES=10, one player, 18 rolls of 0:
  - then 10,10,10 -> 30, gameOver.
  - separate run: 9,1,5 -> 15.
  - separate run: 3,4 -> 7, with gameOver after 2 rolls.
- Async reset: pull reset low mid-cycle after 5 rolls -> all outputs return to reset values before the next edge; a held button does not commit until after re-sync.

Source files
------------

// File: rtl/bowling_scorer.sv
// Multi-player bowling score engine: synchronised roll button, strike/spare bonus
// tracking per player, final-frame fill balls, saturating totals and 7-segment digits.
module bowling_scorer #(
  parameter int PLAYERS = 2,
  parameter int FRAMES  = 10,
  parameter int SCORE_W = 11,
  localparam int PW     = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   pointIn,
  input  logic                         button,
  output logic [PLAYERS*SCORE_W-1:0]   pointAll,
  output logic [PW-1:0]                curPlayer,
  output logic [3:0]                   curFrame,
  output logic [1:0]                   rollInFrame,
  output logic                         gameOver,
  output logic                         illegal,
  output logic [0:6]                   hundred7SegCode,
  output logic [0:6]                   ten7SegCode,
  output logic [0:6]                   current7SegCode
);

  logic sync1_q, sync2_q, prev_q;
  logic commit;

  logic [PLAYERS-1:0][SCORE_W-1:0] total_q, total_d;
  logic [PLAYERS-1:0][1:0]         m1_q, m1_d;
  logic [PLAYERS-1:0]              m2_q, m2_d;
  logic [PW-1:0]                   player_q, player_d;
  logic [3:0]                      frame_q, frame_d;
  logic [1:0]                      roll_q, roll_d;
  logic [3:0]                      rack_q, rack_d;
  logic                            fill_q, fill_d;
  logic                            over_q, over_d;
  logic                            illegal_q, illegal_d;
  logic [3:0]                      last_q, last_d;

  logic [SCORE_W-1:0] cur_total;
  logic [1:0]         cur_m1;
  logic               cur_m2;
  logic               is_final;
  logic [4:0]         pins;
  logic               bad;
  logic [5:0]         add;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] sat;
  logic               frame_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign commit = sync2_q & ~prev_q;

  assign cur_total = total_q[player_q];
  assign cur_m1    = m1_q[player_q];
  assign cur_m2    = m2_q[player_q];
  assign is_final  = (frame_q == 4'(FRAMES));
  // pins already down in the current rack plus this roll; rack_q is 0 on a fresh rack
  assign pins      = 5'(rack_q) + 5'(pointIn);
  assign bad       = (pointIn > 4'd10) || (pins > 5'd10);
  assign add       = 6'(pointIn) * (6'd1 + 6'(cur_m1));
  assign sum       = {1'b0, cur_total} + (SCORE_W+1)'(add);
  assign sat       = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];

  always_comb begin
    total_d   = total_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    player_d  = player_q;
    frame_d   = frame_q;
    roll_d    = roll_q;
    rack_d    = rack_q;
    fill_d    = fill_q;
    over_d    = over_q;
    illegal_d = 1'b0;
    last_d    = last_q;
    frame_end = 1'b0;
    if (commit && !over_q) begin
      if (bad) begin
        illegal_d = 1'b1;
      end else begin
        last_d = pointIn;
        total_d[player_q] = sat;
        if (!is_final) begin
          if (roll_q == 2'd0 && pointIn == 4'd10) begin
            m1_d[player_q] = 2'(cur_m2) + 2'd1;
            m2_d[player_q] = 1'b1;
            frame_end = 1'b1;
          end else if (roll_q == 2'd1 && pins == 5'd10) begin
            m1_d[player_q] = 2'(cur_m2) + 2'd1;
            m2_d[player_q] = 1'b0;
            frame_end = 1'b1;
          end else begin
            m1_d[player_q] = 2'(cur_m2);
            m2_d[player_q] = 1'b0;
            frame_end = (roll_q == 2'd1);
          end
          rack_d = pointIn;
          roll_d = roll_q + 2'd1;
        end else begin
          // final frame only consumes pending bonuses, it never creates new ones
          m1_d[player_q] = 2'(cur_m2);
          m2_d[player_q] = 1'b0;
          case (roll_q)
            2'd0: begin
              fill_d = (pointIn == 4'd10);
              rack_d = (pointIn == 4'd10) ? 4'd0 : pointIn;
              roll_d = 2'd1;
            end
            2'd1: begin
              if (fill_q) begin
                rack_d = (pointIn == 4'd10) ? 4'd0 : pointIn;
                roll_d = 2'd2;
              end else if (pins == 5'd10) begin
                rack_d = 4'd0;
                roll_d = 2'd2;
              end else begin
                frame_end = 1'b1;
              end
            end
            default: frame_end = 1'b1;
          endcase
        end
        if (frame_end) begin
          roll_d = 2'd0;
          rack_d = 4'd0;
          fill_d = 1'b0;
          if (player_q == PW'(PLAYERS-1)) begin
            player_d = '0;
            if (is_final) over_d = 1'b1;
            else          frame_d = frame_q + 4'd1;
          end else begin
            player_d = player_q + PW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_q   <= '0;
      m1_q      <= '0;
      m2_q      <= '0;
      player_q  <= '0;
      frame_q   <= 4'd1;
      roll_q    <= 2'd0;
      rack_q    <= 4'd0;
      fill_q    <= 1'b0;
      over_q    <= 1'b0;
      illegal_q <= 1'b0;
      last_q    <= 4'd0;
    end else begin
      total_q   <= total_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      player_q  <= player_d;
      frame_q   <= frame_d;
      roll_q    <= roll_d;
      rack_q    <= rack_d;
      fill_q    <= fill_d;
      over_q    <= over_d;
      illegal_q <= illegal_d;
      last_q    <= last_d;
    end
  end

  // segment order a..g, value 10 renders as a dash
  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      4'd10:   seg7 = 7'b0000001;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign pointAll        = total_q;
  assign curPlayer       = player_q;
  assign curFrame        = frame_q;
  assign rollInFrame     = roll_q;
  assign gameOver        = over_q;
  assign illegal         = illegal_q;
  assign hundred7SegCode = seg7(4'((32'(cur_total) / 100) % 10));
  assign ten7SegCode     = seg7(4'((32'(cur_total) / 10) % 10));
  assign current7SegCode = seg7(last_q);

endmodule
